// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_ONES_MAX  = 4'd9;
  localparam bcd_t SEC_TENS_MAX  = 4'd5;
  localparam bcd_t MIN_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One modulo-(MAX+1) BCD digit: advances up or down when enabled and carried into,
// with an optional load that overrides the natural roll-over.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = SEC_ONES_MAX
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       down_i,
  input  logic       cin_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] value_o,
  output logic       cout_o
);

  logic advance;
  bcd_t value_next;

  assign advance = en_i & cin_i;
  assign cout_o  = advance & (down_i ? (value_o == 4'd0) : (value_o == MAX));

  always_comb begin
    value_next = value_o;
    if (clear_i) begin
      value_next = 4'd0;
    end else if (advance) begin
      if (load_i) begin
        value_next = load_val_i;
      end else if (down_i) begin
        value_next = (value_o == 4'd0) ? MAX : value_o - 4'd1;
      end else begin
        value_next = (value_o == MAX) ? 4'd0 : value_o + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_o <= 4'd0;
    end else begin
      value_o <= value_next;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch advanced by rising edges of a synchronised slow clock.
// Define STOPWATCH_COUNTDOWN_EN to add dir_i/done_o and down-counting.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_MODULUS = 60
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       slow_clk_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       clear_i,
`ifdef STOPWATCH_COUNTDOWN_EN
  input  logic       dir_i,
  output logic       done_o,
`endif
  output logic [3:0] sec_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] min_tens_o,
  output logic       running_o,
  output logic       wrap_o
);

  localparam bcd_t MIN_MAX_ONES = bcd_t'((MIN_MODULUS - 1) % 10);
  localparam bcd_t MIN_MAX_TENS = bcd_t'((MIN_MODULUS - 1) / 10);

  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  logic tick;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], slow_clk_i};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign tick = sync[SYNC_STAGES-1] & ~prev;

  state_t state, state_next;
  logic   down, count_en, count_done, wrap_next;
  logic   sec_ones_cout, sec_tens_cout, min_ones_cout, min_tens_cout;
  logic   min_at_max, min_at_zero, min_load;
  bcd_t   min_ones_load, min_tens_load;

  assign min_at_max  = (min_tens_o == MIN_MAX_TENS) && (min_ones_o == MIN_MAX_ONES);
  assign min_at_zero = (min_tens_o == 4'd0) && (min_ones_o == 4'd0);

`ifdef STOPWATCH_COUNTDOWN_EN
  logic at_zero, at_one;
  assign down    = dir_i;
  assign at_zero = min_at_zero && (sec_tens_o == 4'd0) && (sec_ones_o == 4'd0);
  assign at_one  = min_at_zero && (sec_tens_o == 4'd0) && (sec_ones_o == 4'd1);
  // Counting down from 00:00 is blocked; the tick only signals completion.
  assign count_en   = (state == RUN) & tick & ~(down & at_zero);
  assign count_done = (state == RUN) & tick & down & (at_zero | at_one);
`else
  assign down       = 1'b0;
  assign count_en   = (state == RUN) & tick;
  assign count_done = 1'b0;
`endif

  // Minutes pair rolls over as one value, so the boundary is forced by a load.
  assign min_load      = sec_tens_cout & (down ? min_at_zero : min_at_max);
  assign min_ones_load = down ? MIN_MAX_ONES : 4'd0;
  assign min_tens_load = down ? MIN_MAX_TENS : 4'd0;
  assign wrap_next     = ~clear_i & ~down & (min_load | min_tens_cout);

  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .en_i       (count_en),
    .down_i     (down),
    .cin_i      (1'b1),
    .load_i     (1'b0),
    .load_val_i (4'd0),
    .value_o    (sec_ones_o),
    .cout_o     (sec_ones_cout)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .en_i       (count_en),
    .down_i     (down),
    .cin_i      (sec_ones_cout),
    .load_i     (1'b0),
    .load_val_i (4'd0),
    .value_o    (sec_tens_o),
    .cout_o     (sec_tens_cout)
  );

  bcd_digit #(.MAX(MIN_DIGIT_MAX)) u_min_ones (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .en_i       (count_en),
    .down_i     (down),
    .cin_i      (sec_tens_cout),
    .load_i     (min_load),
    .load_val_i (min_ones_load),
    .value_o    (min_ones_o),
    .cout_o     (min_ones_cout)
  );

  bcd_digit #(.MAX(MIN_DIGIT_MAX)) u_min_tens (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .en_i       (count_en),
    .down_i     (down),
    .cin_i      (min_ones_cout | min_load),
    .load_i     (min_load),
    .load_val_i (min_tens_load),
    .value_o    (min_tens_o),
    .cout_o     (min_tens_cout)
  );

  always_comb begin
    state_next = state;
    if (clear_i) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start_i) state_next = RUN;
        RUN:     if (stop_i || count_done) state_next = PAUSE;
        PAUSE:   if (start_i) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      wrap_o <= 1'b0;
    end else begin
      state  <= state_next;
      wrap_o <= wrap_next;
    end
  end

`ifdef STOPWATCH_COUNTDOWN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_o <= 1'b0;
    end else begin
      done_o <= count_done & ~clear_i;
    end
  end
`endif

  assign running_o = (state == RUN);

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: two instances (SYNC 2 / MOD 60 and SYNC 3 / MOD 10) driven
// in parallel and compared against a seconds-count reference model.
module tb_stopwatch_bcd;

  localparam int STG [2] = '{2, 3};
  localparam int MODS [2] = '{60, 10};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slow = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic clear = 1'b0;
  logic dir = 1'b0;

  logic [3:0] so [2];
  logic [3:0] st [2];
  logic [3:0] mo [2];
  logic [3:0] mt [2];
  logic       running [2];
  logic       wrap [2];
`ifdef STOPWATCH_COUNTDOWN_EN
  logic       done [2];
  int         done_cnt [2] = '{0, 0};
`endif

  int checks = 0;
  int errors = 0;
  int wrap_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  stopwatch_bcd #(.SYNC_STAGES(2), .MIN_MODULUS(60)) u_dut0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .slow_clk_i (slow),
    .start_i    (start),
    .stop_i     (stop),
    .clear_i    (clear),
`ifdef STOPWATCH_COUNTDOWN_EN
    .dir_i      (dir),
    .done_o     (done[0]),
`endif
    .sec_ones_o (so[0]),
    .sec_tens_o (st[0]),
    .min_ones_o (mo[0]),
    .min_tens_o (mt[0]),
    .running_o  (running[0]),
    .wrap_o     (wrap[0])
  );

  stopwatch_bcd #(.SYNC_STAGES(3), .MIN_MODULUS(10)) u_dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .slow_clk_i (slow),
    .start_i    (start),
    .stop_i     (stop),
    .clear_i    (clear),
`ifdef STOPWATCH_COUNTDOWN_EN
    .dir_i      (dir),
    .done_o     (done[1]),
`endif
    .sec_ones_o (so[1]),
    .sec_tens_o (st[1]),
    .min_ones_o (mo[1]),
    .min_tens_o (mt[1]),
    .running_o  (running[1]),
    .wrap_o     (wrap[1])
  );

  // Reference model: elapsed seconds as one integer, state 0 idle / 1 run / 2 pause.
  bit [7:0] hist;
  int m_total [2] = '{0, 0};
  int m_state [2] = '{0, 0};

  function automatic void model_next(input int tot, input int sta, input bit tk,
                                     input int lim, output int nt, output int ns);
    bit fin = 1'b0;
    nt = tot;
    ns = sta;
    if (clear) begin
      nt = 0;
      ns = 0;
      return;
    end
    if (sta == 1 && tk) begin
      if (dir) begin
        if (tot <= 1) begin
          nt  = 0;
          fin = 1'b1;
        end else begin
          nt = tot - 1;
        end
      end else begin
        nt = (tot == lim - 1) ? 0 : tot + 1;
      end
    end
    if (sta == 1 && (stop || fin)) ns = 2;
    else if (sta != 1 && start) ns = 1;
  endfunction

  always @(posedge clk) begin
    int nt, ns;
    bit tk;
    if (rst) begin
      hist <= '0;
      for (int i = 0; i < 2; i++) begin
        m_total[i] <= 0;
        m_state[i] <= 0;
      end
    end else begin
      hist <= {hist[6:0], slow};
      for (int i = 0; i < 2; i++) begin
        // A rise sampled STG edges ago takes effect at this edge.
        tk = hist[STG[i]-1] & ~hist[STG[i]];
        model_next(m_total[i], m_state[i], tk, MODS[i] * 60, nt, ns);
        m_total[i] <= nt;
        m_state[i] <= ns;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wrap[i]) wrap_cnt[i] <= wrap_cnt[i] + 1;
`ifdef STOPWATCH_COUNTDOWN_EN
      if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
`endif
    end
  end

  function automatic logic [15:0] bcd_of(input int total);
    int s = total % 60;
    int m = total / 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] dig(input int i);
    return {mt[i], mo[i], st[i], so[i]};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rise_ctl(input int hi, input int lo, input int at,
                          input bit s_st, input bit s_sp, input bit s_cl);
    slow = 1'b1;
    for (int c = 0; c < hi + lo; c++) begin
      if (c == hi) slow = 1'b0;
      start = (c == at) && s_st;
      stop  = (c == at) && s_sp;
      clear = (c == at) && s_cl;
      cycle();
    end
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic rise();
    rise_ctl(int'($urandom_range(2, 6)), int'($urandom_range(4, 8)), -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fast_rises(input int n);
    repeat (n) rise_ctl(2, 4, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ctl(input bit s_st, input bit s_sp, input bit s_cl);
    start = s_st;
    stop  = s_sp;
    clear = s_cl;
    cycle();
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({dig(i), running[i], wrap[i]} !== 18'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %h/%b/%b, expected 0000/0/0",
                 i, dig(i), running[i], wrap[i]);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c % 20 == 0) slow = ~slow;
      cycle();
    end
    slow = 1'b0;
    repeat (6) cycle();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({dig(i), running[i]} !== 17'h0 || wrap_cnt[i] != 0) begin
        errors++;
        $display("FAIL idle_no_count dut%0d: got %h run=%b wraps=%0d, expected 0000 0 0",
                 i, dig(i), running[i], wrap_cnt[i]);
      end
    end
  endtask

  task automatic test_count_latency();
    ctl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (running[i] !== 1'b1) begin
        errors++;
        $display("FAIL start_running dut%0d: got %b, expected 1", i, running[i]);
      end
    end
    slow = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dig(i) !== ((k >= STG[i]) ? 16'h0001 : 16'h0000)) begin
          errors++;
          $display("FAIL tick_latency dut%0d edge+%0d: got %h, expected %h", i, k, dig(i),
                   (k >= STG[i]) ? 16'h0001 : 16'h0000);
        end
      end
    end
    slow = 1'b0;
    repeat (6) cycle();
    repeat (74) rise();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dig(i) !== 16'h0115) begin
        errors++;
        $display("FAIL count_75 dut%0d: got %h, expected 0115", i, dig(i));
      end
    end
  endtask

  task automatic test_pause();
    ctl(1'b0, 1'b0, 1'b1);
    ctl(1'b1, 1'b0, 1'b0);
    repeat (30) rise();
    ctl(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dig(i) !== 16'h0030 || running[i] !== 1'b0) begin
        errors++;
        $display("FAIL pause_entry dut%0d: got %h run=%b, expected 0030 0", i, dig(i),
                 running[i]);
      end
    end
    repeat (5) rise();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dig(i) !== 16'h0030) begin
        errors++;
        $display("FAIL pause_hold dut%0d: got %h, expected 0030", i, dig(i));
      end
    end
    ctl(1'b1, 1'b0, 1'b0);
    repeat (2) rise();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dig(i) !== 16'h0032) begin
        errors++;
        $display("FAIL resume dut%0d: got %h, expected 0032", i, dig(i));
      end
    end
  endtask

  task automatic test_wrap();
    int base [2];
    ctl(1'b0, 1'b0, 1'b1);
    ctl(1'b1, 1'b0, 1'b0);
    base = wrap_cnt;
    fast_rises(3599);
    checks++;
    if (dig(0) !== 16'h5959 || wrap_cnt[0] - base[0] != 0) begin
      errors++;
      $display("FAIL preset_max dut0: got %h wraps=%0d, expected 5959 0", dig(0),
               wrap_cnt[0] - base[0]);
    end
    checks++;
    if (dig(1) !== 16'h0959 || wrap_cnt[1] - base[1] != 5) begin
      errors++;
      $display("FAIL preset_max dut1: got %h wraps=%0d, expected 0959 5", dig(1),
               wrap_cnt[1] - base[1]);
    end
    slow = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) slow = 1'b0;
      cycle();
      for (int i = 0; i < 2; i++) begin
        if (wrap[i]) begin
          checks++;
          if (dig(i) !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_digits dut%0d: got %h, expected 0000", i, dig(i));
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dig(i) !== 16'h0000 || wrap_cnt[i] - base[i] != 1 + 5 * i || running[i] !== 1'b1) begin
        errors++;
        $display("FAIL wrap_pulse dut%0d: got %h wraps=%0d run=%b, expected 0000 %0d 1", i,
                 dig(i), wrap_cnt[i] - base[i], running[i], 1 + 5 * i);
      end
    end
    rise();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dig(i) !== 16'h0001) begin
        errors++;
        $display("FAIL after_wrap dut%0d: got %h, expected 0001", i, dig(i));
      end
    end
  endtask

  task automatic test_clear_priority();
    int base [2];
    ctl(1'b0, 1'b0, 1'b1);
    ctl(1'b1, 1'b0, 1'b0);
    fast_rises(754);
    checks++;
    if (dig(0) !== 16'h1234 || dig(1) !== 16'h0234) begin
      errors++;
      $display("FAIL preset_1234: got %h/%h, expected 1234/0234", dig(0), dig(1));
    end
    base = wrap_cnt;
    // Controls land on dut0's update edge (rise edge + 2).
    rise_ctl(4, 4, 2, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dig(i) !== 16'h0000 || running[i] !== 1'b0 || wrap_cnt[i] != base[i]) begin
        errors++;
        $display("FAIL clear_on_tick dut%0d: got %h run=%b wraps=%0d, expected 0000 0 0", i,
                 dig(i), running[i], wrap_cnt[i] - base[i]);
      end
    end
    rise();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dig(i) !== 16'h0000) begin
        errors++;
        $display("FAIL idle_after_clear dut%0d: got %h, expected 0000", i, dig(i));
      end
    end
  endtask

`ifdef STOPWATCH_COUNTDOWN_EN
  task automatic test_countdown();
    int base [2];
    ctl(1'b0, 1'b0, 1'b1);
    ctl(1'b1, 1'b0, 1'b0);
    dir = 1'b0;
    repeat (3) rise();
    dir = 1'b1;
    base = done_cnt;
    for (int k = 1; k <= 3; k++) begin
      rise();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dig(i) !== 16'(3 - k)) begin
          errors++;
          $display("FAIL countdown_step dut%0d: got %h, expected %h", i, dig(i), 16'(3 - k));
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (done_cnt[i] - base[i] != 1 || running[i] !== 1'b0) begin
        errors++;
        $display("FAIL countdown_done dut%0d: got dones=%0d run=%b, expected 1 0", i,
                 done_cnt[i] - base[i], running[i]);
      end
    end
    rise();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dig(i) !== 16'h0000 || done_cnt[i] - base[i] != 1) begin
        errors++;
        $display("FAIL countdown_hold dut%0d: got %h dones=%0d, expected 0000 1", i, dig(i),
                 done_cnt[i] - base[i]);
      end
    end
    dir = 1'b0;
  endtask
`endif

  task automatic test_random();
    int hi, lo;
    for (int n = 0; n < 150; n++) begin
`ifdef STOPWATCH_COUNTDOWN_EN
      if ($urandom_range(0, 7) == 0) dir = ~dir;
`endif
      hi = int'($urandom_range(1, 6));
      lo = int'($urandom_range(4, 8));
      case ($urandom_range(0, 5))
        0: ctl(1'b1, 1'b0, 1'b0);
        1: ctl(1'b0, 1'b1, 1'b0);
        2: ctl(1'(($urandom_range(0, 3) == 0)), 1'b1, 1'(($urandom_range(0, 5) == 0)));
        3: rise_ctl(hi, lo, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'(($urandom_range(0, 7) == 0)));
        default: rise();
      endcase
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dig(i) !== bcd_of(m_total[i]) || running[i] !== (m_state[i] == 1)) begin
          errors++;
          $display("FAIL random_step%0d dut%0d: got %h run=%b, expected %h run=%b", n, i,
                   dig(i), running[i], bcd_of(m_total[i]), m_state[i] == 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_latency();
    test_pause();
    test_wrap();
    test_clear_priority();
`ifdef STOPWATCH_COUNTDOWN_EN
    test_countdown();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
